os2ip_stream: RTL and testbench

OS2IP_STREAM -- requirements
Module: os2ip_stream

---
 rtl/os2ip_stream.sv | 120 ++++++++++++
 tb/tb_os2ip_stream.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/os2ip_stream.sv
// Streaming OS2IP: packs an octet string into an integer, MSB-first (PKCS#1) or LSB-first.
// Define OS2IP_STREAM_OVERFLOW_CHECK_EN to freeze the result and flag strings longer than XLEN_MAX.
module os2ip_stream #(
  parameter int unsigned DATA_BIT_WIDTH = 256,
  parameter bit          LSB_FIRST      = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [7:0]                             in_data,
  input  logic                                   in_valid,
  input  logic                                   in_last,
  output logic                                   in_ready,
  output logic [DATA_BIT_WIDTH-1:0]              out_x,
  output logic [$clog2(DATA_BIT_WIDTH/8+1)-1:0]  out_len,
  output logic                                   out_err,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int unsigned XLEN_MAX = DATA_BIT_WIDTH / 8;
  localparam int unsigned CNT_W    = $clog2(XLEN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN_MAX);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e                    state_q, state_d;
  logic [DATA_BIT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      cnt_full;

  assign cnt_full = (cnt_q == CNT_MAX);

`ifdef OS2IP_STREAM_OVERFLOW_CHECK_EN
  logic err_q, err_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef OS2IP_STREAM_OVERFLOW_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef OS2IP_STREAM_OVERFLOW_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef OS2IP_STREAM_OVERFLOW_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StAccum: begin
        // in_ready is 1 here, so in_valid alone marks an octet handshake
        if (in_valid) begin
          if (!cnt_full) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (LSB_FIRST) begin
            for (int unsigned i = 0; i < XLEN_MAX; i++) begin
              if (cnt_q == CNT_W'(i)) begin
                acc_d[8*i +: 8] = acc_q[8*i +: 8] | in_data;
              end
            end
          end else begin
`ifdef OS2IP_STREAM_OVERFLOW_CHECK_EN
            if (!cnt_full) begin
              acc_d = {acc_q[DATA_BIT_WIDTH-9:0], in_data};
            end
`else
            // Keeps shifting past XLEN_MAX: result is the final XLEN_MAX octets
            acc_d = {acc_q[DATA_BIT_WIDTH-9:0], in_data};
`endif
          end
`ifdef OS2IP_STREAM_OVERFLOW_CHECK_EN
          if (cnt_full) begin
            err_d = 1'b1;
          end
`endif
          if (in_last) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StAccum;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef OS2IP_STREAM_OVERFLOW_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StAccum);
    out_valid = (state_q == StHold);
    out_x     = acc_q;
    out_len   = cnt_q;
`ifdef OS2IP_STREAM_OVERFLOW_CHECK_EN
    out_err   = err_q;
`else
    out_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_os2ip_stream.sv
// Bench for os2ip_stream: an MSB-first and an LSB-first instance share one input stream and are
// compared against an arithmetic model of the octet-string-to-integer conversion.
module tb_os2ip_stream;

  localparam int unsigned W    = 32;
  localparam int unsigned XLEN = W / 8;
  localparam int unsigned LW   = $clog2(XLEN + 1);

  typedef logic [7:0] oct_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_last;
  logic          out_ready;
  logic          in_ready_m, in_ready_l;
  logic [W-1:0]  out_x_m, out_x_l;
  logic [LW-1:0] out_len_m, out_len_l;
  logic          out_err_m, out_err_l;
  logic          out_valid_m, out_valid_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  os2ip_stream #(.DATA_BIT_WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_m),
    .out_x     (out_x_m),
    .out_len   (out_len_m),
    .out_err   (out_err_m),
    .out_valid (out_valid_m),
    .out_ready (out_ready)
  );

  os2ip_stream #(.DATA_BIT_WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_l),
    .out_x     (out_x_l),
    .out_len   (out_len_l),
    .out_err   (out_err_l),
    .out_valid (out_valid_l),
    .out_ready (out_ready)
  );

  // Reference: integer value of the string as plain arithmetic.
  function automatic logic [W-1:0] exp_x(input oct_t q[$], input bit lsb);
    longint unsigned v;
    int n;
    int keep;
    v    = 0;
    n    = q.size();
    keep = (n > int'(XLEN)) ? int'(XLEN) : n;
    if (lsb) begin
      for (int i = 0; i < keep; i++) v = v + (longint'(q[i]) << (8 * i));
    end else begin
`ifdef OS2IP_STREAM_OVERFLOW_CHECK_EN
      for (int i = 0; i < keep; i++) v = v * 256 + q[i];
`else
      for (int i = 0; i < n; i++) v = (v * 256 + q[i]) % (64'd1 << W);
`endif
    end
    return W'(v);
  endfunction

  function automatic logic [LW-1:0] exp_len(input oct_t q[$]);
    return LW'((q.size() > int'(XLEN)) ? int'(XLEN) : q.size());
  endfunction

  function automatic logic exp_err(input oct_t q[$]);
`ifdef OS2IP_STREAM_OVERFLOW_CHECK_EN
    return q.size() > int'(XLEN);
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_last   = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid_m, out_x_m, out_len_m, out_err_m} !== {1'b0, W'(0), LW'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold_m: got v=%b x=%h len=%0d err=%b, want 0/0/0/0",
               out_valid_m, out_x_m, out_len_m, out_err_m);
    end
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready_m, out_valid_m, out_x_m, out_len_m, out_err_m} !==
        {1'b1, 1'b0, W'(0), LW'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release_m: got rdy=%b v=%b x=%h len=%0d err=%b, want 1/0/0/0/0",
               in_ready_m, out_valid_m, out_x_m, out_len_m, out_err_m);
    end
    n_checks++;
    if ({in_ready_l, out_valid_l, out_x_l, out_len_l, out_err_l} !==
        {1'b1, 1'b0, W'(0), LW'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release_l: got rdy=%b v=%b x=%h len=%0d err=%b, want 1/0/0/0/0",
               in_ready_l, out_valid_l, out_x_l, out_len_l, out_err_l);
    end
  endtask

  // Sends one string (optionally with idle gaps), checks the result, holds it, then releases it.
  task automatic run_string(input string name, input oct_t q[$], input int gap_pct,
                            input int hold);
    int i;
    int guard;
    bit hs;
    logic [W+LW:0] ex_m, ex_l;
    i     = 0;
    guard = 0;
    out_ready = 1'b0;
    while (i < q.size() && guard < 200) begin
      guard++;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = q[i];
        in_last  = (i == q.size() - 1);
      end
      hs = in_valid && in_ready_m;
      @(posedge clk);
      #1;
      if (hs) i++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (i < q.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: accepted %0d of %0d octets", name, i, q.size());
      return;
    end
    n_checks++;
    if ({out_valid_m, out_valid_l, in_ready_m, in_ready_l} !== 4'b1100) begin
      n_fail++;
      $display("FAIL %s_latency: got v_m/v_l/rdy_m/rdy_l=%b%b%b%b, want 1100", name,
               out_valid_m, out_valid_l, in_ready_m, in_ready_l);
    end
    ex_m = {exp_x(q, 1'b0), exp_len(q), exp_err(q)};
    ex_l = {exp_x(q, 1'b1), exp_len(q), exp_err(q)};
    n_checks++;
    if ({out_x_m, out_len_m, out_err_m} !== ex_m) begin
      n_fail++;
      $display("FAIL %s_msb: got x=%h len=%0d err=%b, want x=%h len=%0d err=%b", name,
               out_x_m, out_len_m, out_err_m, ex_m[W+LW:LW+1], ex_m[LW:1], ex_m[0]);
    end
    n_checks++;
    if ({out_x_l, out_len_l, out_err_l} !== ex_l) begin
      n_fail++;
      $display("FAIL %s_lsb: got x=%h len=%0d err=%b, want x=%h len=%0d err=%b", name,
               out_x_l, out_len_l, out_err_l, ex_l[W+LW:LW+1], ex_l[LW:1], ex_l[0]);
    end
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid_m, in_ready_m, out_x_m, out_len_m, out_err_m} !== {2'b10, ex_m} ||
          {out_valid_l, in_ready_l, out_x_l, out_len_l, out_err_l} !== {2'b10, ex_l}) begin
        n_fail++;
        $display("FAIL %s_hold%0d: got m v=%b rdy=%b x=%h l v=%b rdy=%b x=%h, want stable", name,
                 c, out_valid_m, in_ready_m, out_x_m, out_valid_l, in_ready_l, out_x_l);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid_m, in_ready_m, out_valid_l, in_ready_l} !== 4'b0101) begin
      n_fail++;
      $display("FAIL %s_release: got v_m/rdy_m/v_l/rdy_l=%b%b%b%b, want 0101", name,
               out_valid_m, in_ready_m, out_valid_l, in_ready_l);
    end
  endtask

  task automatic test_known();
    oct_t q[$];
    q = {8'h12, 8'h34, 8'h56, 8'h78};
    run_string("full4", q, 0, 0);
    q = {8'hAB, 8'hCD};
    run_string("short2", q, 0, 0);
    q = {8'h5A};
    run_string("single", q, 0, 0);
  endtask

  task automatic test_overflow();
    oct_t q[$];
    q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_string("overflow5", q, 0, 0);
  endtask

  task automatic test_backpressure();
    oct_t q[$];
    q = {8'hDE, 8'hAD, 8'hBE};
    run_string("backpressure", q, 0, 3);
  endtask

  task automatic test_reset_midstring();
    oct_t q[$];
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_data  = 8'hAA;
    @(posedge clk);
    #1;
    in_data = 8'hBB;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if ({in_ready_m, out_x_m, out_len_m, out_x_l, out_len_l} !==
        {1'b1, W'(0), LW'(0), W'(0), LW'(0)}) begin
      n_fail++;
      $display("FAIL midreset_clear: got rdy=%b x_m=%h len_m=%0d x_l=%h len_l=%0d, want 1/0/0/0/0",
               in_ready_m, out_x_m, out_len_m, out_x_l, out_len_l);
    end
    q = {8'h01, 8'h02};
    run_string("after_reset", q, 0, 0);
  endtask

  task automatic test_back_to_back();
    oct_t oct[8];
    oct_t s0[$];
    oct_t s1[$];
    logic [W+LW:0] res_m[2];
    logic [W+LW:0] res_l[2];
    int i;
    int gaps;
    int got;
    bit hs;
    oct = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    s0  = {8'h12, 8'h34, 8'h56, 8'h78};
    s1  = {8'h9A, 8'hBC, 8'hDE, 8'hF0};
    i    = 0;
    gaps = 0;
    got  = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
      if (out_valid_m) begin
        res_m[got] = {out_x_m, out_len_m, out_err_m};
        res_l[got] = {out_x_l, out_len_l, out_err_l};
        got++;
      end
      in_valid = 1'b1;
      in_data  = oct[(i < 8) ? i : 0];
      in_last  = (i % 4 == 3);
      if (i > 0 && i < 8 && !in_ready_m) gaps++;
      hs = (i < 8) && in_ready_m;
      @(posedge clk);
      #1;
      if (hs) i++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (got != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, want 2", got);
    end else begin
      n_checks++;
      if (res_m[0] !== {exp_x(s0, 1'b0), exp_len(s0), exp_err(s0)} ||
          res_m[1] !== {exp_x(s1, 1'b0), exp_len(s1), exp_err(s1)}) begin
        n_fail++;
        $display("FAIL b2b_msb: got %h / %h, want x=%h / %h", res_m[0], res_m[1],
                 exp_x(s0, 1'b0), exp_x(s1, 1'b0));
      end
      n_checks++;
      if (res_l[0] !== {exp_x(s0, 1'b1), exp_len(s0), exp_err(s0)} ||
          res_l[1] !== {exp_x(s1, 1'b1), exp_len(s1), exp_err(s1)}) begin
        n_fail++;
        $display("FAIL b2b_lsb: got %h / %h, want x=%h / %h", res_l[0], res_l[1],
                 exp_x(s0, 1'b1), exp_x(s1, 1'b1));
      end
    end
    n_checks++;
    if (gaps != 1) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d in_ready=0 cycles between strings, want 1", gaps);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    oct_t q[$];
    int len;
    for (int s = 0; s < 40; s++) begin
      q.delete();
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) q.push_back(8'($urandom));
      run_string($sformatf("rand%0d", s), q, 25, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_overflow();
    test_backpressure();
    test_reset_midstring();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
